multdiv: RTL and testbench

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv_if.sv | 21 ++
 rtl/multdiv.sv | 180 ++++++++++++++++++
 tb/tb_multdiv.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/multdiv_if.sv
// Operand, control and result signals between the execute stage and the multiply/divide unit.
interface multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring), result 33 cycles after start.
// Define MULTDIV_DIV_EN to build the divider; without it a divide start reports an exception after one cycle.
module multdiv (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave io
);

`ifdef MULTDIV_DIV_EN
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
`endif

    state_t      r_state;
    state_t      w_state_next;
    state_t      w_start_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_prod;
    logic [31:0] r_mcand;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_start;
    logic        w_cnt_done;
    logic        w_mult_last;
    logic        w_mult_ovf;
    logic [32:0] w_booth_sum;
    logic [64:0] w_booth_next;

    assign w_start    = io.ctrl_MULT | io.ctrl_DIV;
    assign w_cnt_done = (r_cnt == 6'd32);
    // Product lives in r_prod[64:1] once all 32 steps have shifted through.
    assign w_mult_ovf = (r_prod[64:33] != {32{r_prod[32]}});

    assign io.data_result    = r_result;
    assign io.data_exception = r_exc;

`ifdef MULTDIV_DIV_EN
    logic        r_neg;
    logic        r_dz;
    logic        r_ovf;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_rem;
    logic [64:0] w_div_next;
    logic [31:0] w_quot;

    assign w_start_state = io.ctrl_MULT ? MULT : DIV;
    assign w_mult_last   = w_cnt_done;

    assign w_absA = io.data_operandA[31] ? (32'd0 - io.data_operandA) : io.data_operandA;
    assign w_absB = io.data_operandB[31] ? (32'd0 - io.data_operandB) : io.data_operandB;

    // r_prod holds {partial remainder[32:0], dividend/quotient[31:0]}; 33 bits covers [-2D, 2D).
    assign w_div_shift = {r_prod[63:32], r_prod[31]};
    assign w_div_rem   = r_prod[64] ? (w_div_shift + {1'b0, r_mcand})
                                    : (w_div_shift - {1'b0, r_mcand});
    assign w_div_next  = {w_div_rem, r_prod[30:0], ~w_div_rem[32]};
    assign w_quot      = r_neg ? (32'd0 - r_prod[31:0]) : r_prod[31:0];
`else
    logic r_is_div;

    assign w_start_state = MULT;
    assign w_mult_last   = r_is_div | w_cnt_done;
`endif

    // Booth add is done one bit wider so a most-negative multiplicand cannot overflow the accumulator.
    always_comb begin
        w_booth_sum = {r_prod[64], r_prod[64:33]};
        case (r_prod[1:0])
            2'b01:   w_booth_sum = {r_prod[64], r_prod[64:33]} + {r_mcand[31], r_mcand};
            2'b10:   w_booth_sum = {r_prod[64], r_prod[64:33]} - {r_mcand[31], r_mcand};
            default: ;
        endcase
        w_booth_next = {w_booth_sum, r_prod[32:1]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        io.busy           = 1'b0;
        io.data_resultRDY = 1'b0;
        case (r_state)
            MULT: begin
                io.busy = 1'b1;
                if (w_mult_last) w_state_next = DONE;
            end
`ifdef MULTDIV_DIV_EN
            DIV: begin
                io.busy = 1'b1;
                if (w_cnt_done) w_state_next = DONE;
            end
`endif
            DONE: begin
                io.data_resultRDY = 1'b1;
                w_state_next      = IDLE;
            end
            default: ;
        endcase
        if (w_start) w_state_next = w_start_state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
`ifdef MULTDIV_DIV_EN
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
`else
            r_is_div <= 1'b0;
`endif
        end else if (w_start) begin
            r_cnt <= '0;
            if (io.ctrl_MULT) begin
                r_prod  <= {32'd0, io.data_operandB, 1'b0};
                r_mcand <= io.data_operandA;
`ifndef MULTDIV_DIV_EN
                r_is_div <= 1'b0;
`endif
            end else begin
`ifdef MULTDIV_DIV_EN
                r_prod  <= {33'd0, w_absA};
                r_mcand <= w_absB;
                r_neg   <= io.data_operandA[31] ^ io.data_operandB[31];
                r_dz    <= (io.data_operandB == '0);
                r_ovf   <= (io.data_operandA == 32'h8000_0000) && (io.data_operandB == '1);
`else
                r_is_div <= 1'b1;
`endif
            end
        end else if (r_state == MULT) begin
            if (w_mult_last) begin
`ifdef MULTDIV_DIV_EN
                r_result <= r_prod[32:1];
                r_exc    <= w_mult_ovf;
`else
                r_result <= r_is_div ? 32'd0 : r_prod[32:1];
                r_exc    <= r_is_div | w_mult_ovf;
`endif
            end else begin
                r_prod <= w_booth_next;
                r_cnt  <= r_cnt + 6'd1;
            end
        end
`ifdef MULTDIV_DIV_EN
        else if (r_state == DIV) begin
            if (w_cnt_done) begin
                if (r_dz) begin
                    r_result <= '0;
                    r_exc    <= 1'b1;
                end else if (r_ovf) begin
                    r_result <= 32'h8000_0000;
                    r_exc    <= 1'b1;
                end else begin
                    r_result <= w_quot;
                    r_exc    <= 1'b0;
                end
            end else begin
                r_prod <= w_div_next;
                r_cnt  <= r_cnt + 6'd1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: driver queues expected results, a negedge monitor checks each ready pulse.
module tb_multdiv;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    exp_t        sb[$];

    multdiv_if io ();

    multdiv dut (
        .clock (clk),
        .reset (rst),
        .io    (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest pending expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && io.data_resultRDY) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, io.data_result, e.res);
                chk({e.name, "_exception"}, {31'd0, io.data_exception}, {31'd0, e.exc});
                chk({e.name, "_rdy_cycle"}, cyc, e.cyc);
                chk({e.name, "_busy_at_rdy"}, {31'd0, io.busy}, 32'd0);
            end
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ee, input int unsigned lat, input string nm);
        exp_t e;
        @(negedge clk);
        io.data_operandA = a;
        io.data_operandB = b;
        io.ctrl_MULT     = m;
        io.ctrl_DIV      = d;
        e.res  = er;
        e.exc  = ee;
        e.cyc  = cyc + 1 + lat;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        io.ctrl_MULT     = 1'b0;
        io.ctrl_DIV      = 1'b0;
        io.data_operandA = $urandom();
        io.data_operandB = $urandom();
        chk({nm, "_busy_after_start"}, {31'd0, io.busy}, 32'd1);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        chk({nm, "_timeout_pending"}, sb.size(), 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

`ifdef MULTDIV_DIV_EN
    localparam int unsigned DLAT = 33;
`else
    localparam int unsigned DLAT = 1;
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        io.data_operandA = '0;
        io.data_operandB = '0;
        io.ctrl_MULT     = 1'b0;
        io.ctrl_DIV      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_result", io.data_result, 32'd0);
        chk("reset_exception", {31'd0, io.data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, io.data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, io.busy}, 32'd0);
        rst = 1'b0;

        // Multiply vectors
        start_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, "mul_7x-3");
        wait_done("mul_7x-3");
        start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33, "mul_ovf");
        wait_done("mul_ovf");
        start_op(1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30, 1'b0, 33, "mul_-5x-6");
        wait_done("mul_-5x-6");
        start_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 33, "mul_min_min");
        wait_done("mul_min_min");
        start_op(1, 0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1, 33, "mul_-1xmin");
        wait_done("mul_-1xmin");
        start_op(1, 0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, 33, "mul_max_x1");
        wait_done("mul_max_x1");

        // Simultaneous start: multiply wins
        start_op(1, 1, 32'd6, 32'd3, 32'd18, 1'b0, 33, "both_6x3");
        wait_done("both_6x3");

        // Divide vectors
`ifdef MULTDIV_DIV_EN
        start_op(0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 33, "div_-100/7");
        wait_done("div_-100/7");
        start_op(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, 33, "div_by_zero");
        wait_done("div_by_zero");
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, "div_min/-1");
        wait_done("div_min/-1");
        start_op(0, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, "div_7/-2");
        wait_done("div_7/-2");
        start_op(0, 1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, "div_-1/min");
        wait_done("div_-1/min");
`else
        start_op(0, 1, 32'd6, 32'd3, 32'd0, 1'b1, 1, "div_stub_6/3");
        wait_done("div_stub_6/3");
        start_op(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, 1, "div_stub_5/0");
        wait_done("div_stub_5/0");
`endif

        // Restart: MULT 3x4 at N, new start at N+10
        start_op(1, 0, 32'd3, 32'd4, 32'd12, 1'b0, 33, "restart_first");
        repeat (8) @(negedge clk);
        void'(sb.pop_back());
`ifdef MULTDIV_DIV_EN
        start_op(0, 1, 32'd100, 32'd10, 32'd10, 1'b0, DLAT, "restart_div");
`else
        start_op(0, 1, 32'd100, 32'd10, 32'd0, 1'b1, DLAT, "restart_div");
`endif
        wait_done("restart_div");
        start_op(1, 0, 32'd3, 32'd4, 32'd12, 1'b0, 33, "restart_first2");
        repeat (8) @(negedge clk);
        void'(sb.pop_back());
        start_op(1, 0, 32'd5, 32'd5, 32'd25, 1'b0, 33, "restart_mul");
        wait_done("restart_mul");

        // Reset mid-operation
        start_op(1, 0, 32'd9, 32'd9, 32'd81, 1'b0, 33, "reset_mid");
        repeat (20) @(negedge clk);
        void'(sb.pop_back());
        #1 rst = 1'b1;
        #1;
        chk("midreset_result", io.data_result, 32'd0);
        chk("midreset_exception", {31'd0, io.data_exception}, 32'd0);
        chk("midreset_rdy", {31'd0, io.data_resultRDY}, 32'd0);
        chk("midreset_busy", {31'd0, io.busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        start_op(1, 0, 32'd2, 32'd2, 32'd4, 1'b0, 33, "post_reset_2x2");
        wait_done("post_reset_2x2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
